// File: rtl/store_queue.sv
// store_queue: in-order store buffer between the issue stage and memory.
// Stores are accepted once all three operands are ready, the address is
// formed on entry, and only the head entry is presented to memory until it
// commits. Optional load forwarding is enabled by defining STORE_QUEUE_FWD_EN.
module store_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4,
    parameter int XLEN  = 32
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       in_valid,
    input  logic [XLEN-1:0]            V1,
    input  logic [XLEN-1:0]            V2,
    input  logic [XLEN-1:0]            V3,
    input  logic                       V1_valid,
    input  logic                       V2_valid,
    input  logic                       V3_valid,
    input  logic [TAG_W-1:0]           in_tag,
    input  logic [2:0]                 mem_type,
    output logic                       in_ready,
    output logic [XLEN-1:0]            MEM_ADDR2,
    output logic [XLEN-1:0]            MEM_WRITE_DATA,
    output logic                       MEM_WRITE,
    output logic                       MEM_SIGN,
    output logic [1:0]                 MEM_SIZE,
    input  logic                       mem_resp_valid,
    input  logic                       mem_resp,
    output logic                       done,
    output logic [TAG_W-1:0]           done_tag,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    input  logic [XLEN-1:0]            ld_addr,
    output logic                       fwd_hit,
    output logic [XLEN-1:0]            fwd_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [XLEN-1:0]  addr;
        logic [XLEN-1:0]  data;
        logic             sign;
        logic [1:0]       size;
        logic [TAG_W-1:0] tag;
    } entry_t;

    typedef enum logic {IDLE, REQ} state_t;

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    state_t           state_q, state_d;
    logic             done_q, done_d;
    logic [TAG_W-1:0] done_tag_q, done_tag_d;
    logic             enq, pop;
    entry_t           head_e;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign enq       = in_valid && V1_valid && V2_valid && V3_valid && !full && !RST;
    assign in_ready  = enq;
    assign pop       = (state_q == REQ) && mem_resp_valid && mem_resp;
    assign head_e    = ent_q[head_q];
    assign done      = done_q;
    assign done_tag  = done_tag_q;

    // Head fields are only driven while a request is outstanding so stale
    // entries never leak onto the memory bus after the queue drains.
    assign MEM_WRITE      = (state_q == REQ);
    assign MEM_ADDR2      = MEM_WRITE ? head_e.addr : '0;
    assign MEM_WRITE_DATA = MEM_WRITE ? head_e.data : '0;
    assign MEM_SIGN       = MEM_WRITE ? head_e.sign : 1'b0;
    assign MEM_SIZE       = MEM_WRITE ? head_e.size : 2'b00;

    // Next-state: enqueue at tail, pop at head, completion pulse, head FSM.
    always_comb begin
        ent_d      = ent_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        done_d     = 1'b0;
        done_tag_d = '0;
        if (enq) begin
            ent_d[tail_q] = '{addr: V1 + V2, data: V3, sign: mem_type[2],
                              size: mem_type[1:0], tag: in_tag};
            tail_d = tail_q + 1'b1;
        end
        if (pop) begin
            head_d     = head_q + 1'b1;
            done_d     = 1'b1;
            done_tag_d = head_e.tag;
        end
        if (enq && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !enq)
            count_d = count_q - 1'b1;
        // Registered off the next count, so a fresh entry is presented one
        // cycle after enqueue and the successor right after a pop.
        state_d = (count_d != '0) ? REQ : IDLE;
    end

    // State registers; reset discards all pending stores silently.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            state_q    <= IDLE;
            done_q     <= 1'b0;
            done_tag_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            state_q    <= state_d;
            done_q     <= done_d;
            done_tag_q <= done_tag_d;
        end
    end

`ifdef STORE_QUEUE_FWD_EN
    logic [AW-1:0] fwd_idx;

    // Scan oldest to youngest so the last word-sized match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + AW'(i);
            if ((CW'(i) < count_q) && (ent_q[fwd_idx].size == 2'b10) &&
                (ent_q[fwd_idx].addr == ld_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = ent_q[fwd_idx].data;
            end
        end
    end
`else
    logic [XLEN-1:0] unused_ld_addr;
    assign unused_ld_addr = ld_addr;
    assign fwd_hit        = 1'b0;
    assign fwd_data       = '0;
`endif
endmodule

// File: tb/tb_store_queue.sv
// Self-checking bench for store_queue (DEPTH=4). Expected head entries are
// queued when a store is driven and checked when memory commits it.
module tb_store_queue;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int XLEN  = 32;

    logic             CLK, RST;
    logic             in_valid, V1_valid, V2_valid, V3_valid;
    logic [XLEN-1:0]  V1, V2, V3, ld_addr;
    logic [TAG_W-1:0] in_tag;
    logic [2:0]       mem_type;
    logic             in_ready, MEM_WRITE, MEM_SIGN, mem_resp_valid, mem_resp;
    logic [XLEN-1:0]  MEM_ADDR2, MEM_WRITE_DATA, fwd_data;
    logic [1:0]       MEM_SIZE;
    logic             done, full, empty, fwd_hit;
    logic [TAG_W-1:0] done_tag;
    logic [2:0]       count;

    store_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .V1(V1), .V2(V2), .V3(V3),
        .V1_valid(V1_valid), .V2_valid(V2_valid), .V3_valid(V3_valid),
        .in_tag(in_tag), .mem_type(mem_type), .in_ready(in_ready),
        .MEM_ADDR2(MEM_ADDR2), .MEM_WRITE_DATA(MEM_WRITE_DATA),
        .MEM_WRITE(MEM_WRITE), .MEM_SIGN(MEM_SIGN), .MEM_SIZE(MEM_SIZE),
        .mem_resp_valid(mem_resp_valid), .mem_resp(mem_resp), .done(done),
        .done_tag(done_tag), .count(count), .full(full), .empty(empty),
        .ld_addr(ld_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data));

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  addr;
        logic [XLEN-1:0]  data;
        logic [2:0]       mt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   mcount = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    // Present a store; the model records it only if the queue has room.
    task automatic drive_enq(input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] v1,
                             input logic [XLEN-1:0] v2, input logic [XLEN-1:0] v3,
                             input logic [2:0] mt);
        exp_t e;
        in_valid = 1'b1; V1_valid = 1'b1; V2_valid = 1'b1; V3_valid = 1'b1;
        V1 = v1; V2 = v2; V3 = v3; in_tag = tag; mem_type = mt;
        if (mcount < DEPTH) begin
            e.tag = tag; e.addr = v1 + v2; e.data = v3; e.mt = mt;
            sb.push_back(e);
            mcount++;
        end
    endtask

    // Commit the head: compare it to the oldest expected store, then the done pulse.
    task automatic pop_step();
        exp_t e;
        if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL sb_empty: got no expected entry want one");
            return;
        end
        e = sb.pop_front();
        total++; if (MEM_WRITE !== 1'b1) begin bad++; $display("FAIL pop_mem_write: got %b want 1", MEM_WRITE); end
        total++; if (MEM_ADDR2 !== e.addr) begin bad++; $display("FAIL pop_addr: got %h want %h", MEM_ADDR2, e.addr); end
        total++; if (MEM_WRITE_DATA !== e.data) begin bad++; $display("FAIL pop_data: got %h want %h", MEM_WRITE_DATA, e.data); end
        total++; if ({MEM_SIGN, MEM_SIZE} !== e.mt) begin bad++; $display("FAIL pop_type: got %b want %b", {MEM_SIGN, MEM_SIZE}, e.mt); end
        mem_resp_valid = 1'b1; mem_resp = 1'b1;
        @(negedge CLK);
        mcount--;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL pop_done: got %b want 1", done); end
        total++; if (done_tag !== e.tag) begin bad++; $display("FAIL pop_tag: got %h want %h", done_tag, e.tag); end
        mem_resp_valid = 1'b0; mem_resp = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        in_valid = 1'b1; V1_valid = 1'b1; V2_valid = 1'b1; V3_valid = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        @(negedge CLK); @(negedge CLK);
        total++; if (MEM_WRITE !== 1'b0) begin bad++; $display("FAIL rst_mem_write: got %b want 0", MEM_WRITE); end
        total++; if (done !== 1'b0 || done_tag !== '0) begin bad++; $display("FAIL rst_done: got %b/%h want 0/0", done, done_tag); end
        total++; if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL rst_count: got %0d e%b f%b want 0 e1 f0", count, empty, full); end
        total++; if (MEM_ADDR2 !== '0 || MEM_WRITE_DATA !== '0 || MEM_SIZE !== 2'b0 || MEM_SIGN !== 1'b0) begin bad++; $display("FAIL rst_head: got %h %h %b %b want zeros", MEM_ADDR2, MEM_WRITE_DATA, MEM_SIZE, MEM_SIGN); end
        total++; if (fwd_hit !== 1'b0) begin bad++; $display("FAIL rst_fwd: got %b want 0", fwd_hit); end
        RST = 1'b0; in_valid = 1'b0;
        mem_resp_valid = 1'b1; mem_resp = 1'b1;
        @(negedge CLK);
        total++; if (done !== 1'b0 || empty !== 1'b1) begin bad++; $display("FAIL idle_resp: got done%b e%b want done0 e1", done, empty); end
        mem_resp_valid = 1'b0; mem_resp = 1'b0;
    endtask

    task automatic test_single();
        drive_enq(4'd3, 32'h100, 32'h4, 32'hDEADBEEF, 3'b010);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL single_ready: got %b want 1", in_ready); end
        total++; if (MEM_WRITE !== 1'b0) begin bad++; $display("FAIL single_latency: got %b want 0", MEM_WRITE); end
        @(negedge CLK);
        in_valid = 1'b0;
        total++; if (MEM_ADDR2 !== 32'h104 || count !== 3'd1) begin bad++; $display("FAIL single_present: got %h c%0d want 104 c1", MEM_ADDR2, count); end
        pop_step();
        total++; if (empty !== 1'b1 || MEM_WRITE !== 1'b0) begin bad++; $display("FAIL single_empty: got e%b w%b want e1 w0", empty, MEM_WRITE); end
        @(negedge CLK);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL single_pulse: got %b want 0", done); end
    endtask

    task automatic test_fill();
        in_valid = 1'b1; V1_valid = 1'b1; V2_valid = 1'b0; V3_valid = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL op_not_ready: got %b want 0", in_ready); end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_enq(TAG_W'(i), 32'h1000 + 32'(i) * 16, 32'h0, 32'hA0 + 32'(i), 3'b010);
            #1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fill_ready%0d: got %b want 1", i, in_ready); end
            @(negedge CLK);
        end
        total++; if (full !== 1'b1 || count !== 3'd4) begin bad++; $display("FAIL fill_full: got f%b c%0d want f1 c4", full, count); end
        drive_enq(4'd4, 32'h2000, 32'h0, 32'hFF, 3'b010);
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_fifth: got %b want 0", in_ready); end
        @(negedge CLK);
        in_valid = 1'b0;
        total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_hold: got %0d want 4", count); end
        for (int i = 0; i < 4; i++) pop_step();
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL fill_drain: got %b want 1", empty); end
    endtask

    task automatic test_retry();
        drive_enq(4'd5, 32'h300, 32'h8, 32'h55, 3'b101);
        @(negedge CLK);
        in_valid = 1'b0;
        for (int r = 0; r < 2; r++) begin
            mem_resp_valid = 1'b1; mem_resp = 1'b0;
            @(negedge CLK);
            total++; if (MEM_WRITE !== 1'b1 || MEM_ADDR2 !== 32'h308 || MEM_WRITE_DATA !== 32'h55 || {MEM_SIGN, MEM_SIZE} !== 3'b101)
                begin bad++; $display("FAIL retry_hold%0d: got w%b %h %h %b want w1 308 55 101", r, MEM_WRITE, MEM_ADDR2, MEM_WRITE_DATA, {MEM_SIGN, MEM_SIZE}); end
            total++; if (done !== 1'b0) begin bad++; $display("FAIL retry_done%0d: got %b want 0", r, done); end
        end
        pop_step();
        @(negedge CLK);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL retry_single: got %b want 0", done); end
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 4; i++) begin
            drive_enq(TAG_W'(8 + i), 32'h500 + 32'(i) * 4, 32'h0, 32'hB0 + 32'(i), 3'b010);
            @(negedge CLK);
        end
        drive_enq(4'd12, 32'h600, 32'h0, 32'hCC, 3'b010);
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fullpop_refuse: got %b want 0", in_ready); end
        pop_step();
        total++; if (count !== 3'd3) begin bad++; $display("FAIL fullpop_c3: got %0d want 3", count); end
        drive_enq(4'd12, 32'h600, 32'h0, 32'hCC, 3'b010);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fullpop_accept: got %b want 1", in_ready); end
        @(negedge CLK);
        in_valid = 1'b0;
        total++; if (count !== 3'd4 || full !== 1'b1) begin bad++; $display("FAIL fullpop_c4: got %0d f%b want 4 f1", count, full); end
        for (int i = 0; i < 4; i++) pop_step();
    endtask

    task automatic test_wrap();
        drive_enq(4'd0, 32'h400, 32'h0, 32'h0, 3'b010);
        @(negedge CLK);
        in_valid = 1'b0;
        for (int i = 1; i < 10; i++) begin
            drive_enq(TAG_W'(i), 32'h400 + 32'(i) * 4, 32'h0, 32'(i) * 32'h111, 3'b010);
            #1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL wrap_ready%0d: got %b want 1", i, in_ready); end
            pop_step();
            total++; if (count !== 3'd1) begin bad++; $display("FAIL wrap_count%0d: got %0d want 1", i, count); end
        end
        pop_step();
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL wrap_empty: got %b want 1", empty); end
    endtask

    task automatic test_rst_mid();
        for (int i = 1; i < 4; i++) begin
            drive_enq(TAG_W'(i), 32'h700 + 32'(i), 32'h0, 32'(i), 3'b010);
            @(negedge CLK);
        end
        RST = 1'b1;
        in_valid = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rstmid_ready: got %b want 0", in_ready); end
        @(negedge CLK);
        RST = 1'b0; in_valid = 1'b0;
        sb.delete(); mcount = 0;
        total++; if (MEM_WRITE !== 1'b0 || count !== 3'd0 || done !== 1'b0 || empty !== 1'b1)
            begin bad++; $display("FAIL rstmid_clear: got w%b c%0d d%b e%b want w0 c0 d0 e1", MEM_WRITE, count, done, empty); end
        @(negedge CLK);
        total++; if (done !== 1'b0 || MEM_WRITE !== 1'b0) begin bad++; $display("FAIL rstmid_quiet: got d%b w%b want d0 w0", done, MEM_WRITE); end
    endtask

    task automatic test_fwd();
        drive_enq(4'd1, 32'h200, 32'h0, 32'h11, 3'b010);
        @(negedge CLK);
        drive_enq(4'd2, 32'h1F0, 32'h10, 32'h22, 3'b010);
        @(negedge CLK);
        drive_enq(4'd3, 32'h200, 32'h0, 32'h33, 3'b000);
        @(negedge CLK);
        in_valid = 1'b0;
        ld_addr = 32'h200;
        #1;
`ifdef STORE_QUEUE_FWD_EN
        total++; if (fwd_hit !== 1'b1 || fwd_data !== 32'h22) begin bad++; $display("FAIL fwd_youngest: got %b %h want 1 22", fwd_hit, fwd_data); end
        ld_addr = 32'h204;
        #1;
        total++; if (fwd_hit !== 1'b0) begin bad++; $display("FAIL fwd_miss: got %b want 0", fwd_hit); end
`else
        total++; if (fwd_hit !== 1'b0 || fwd_data !== '0) begin bad++; $display("FAIL fwd_off: got %b %h want 0 0", fwd_hit, fwd_data); end
`endif
        for (int i = 0; i < 3; i++) pop_step();
    endtask

    initial begin
        RST = 1'b1; in_valid = 1'b0; V1_valid = 1'b0; V2_valid = 1'b0; V3_valid = 1'b0;
        V1 = '0; V2 = '0; V3 = '0; in_tag = '0; mem_type = '0;
        mem_resp_valid = 1'b0; mem_resp = 1'b0; ld_addr = '0;
        test_reset();
        test_single();
        test_fill();
        test_retry();
        test_full_pop();
        test_wrap();
        test_rst_mid();
        test_fwd();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/store_queue.md
STORE_QUEUE -- requirements
Module: store_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered stores (power of two, >=2).
REQ-002 SHALL have parameter TAG_W, default 4, width of the reservation-station destination tag.
REQ-003 SHALL have parameter XLEN, default 32, address/data width.
REQ-004 CLK  input  1  sole clock; all state updates on rising edge.
REQ-005 RST  input  1  reset, synchronous and active-high.
REQ-006 in_valid  input  1  issue slot presents a store.
REQ-007 V1, V2, V3  input  XLEN each  base, offset, store data.
REQ-008 V1_valid, V2_valid, V3_valid  input  1 each  operand-ready flags.
REQ-009 in_tag  input  TAG_W  tag of the store.
REQ-010 mem_type  input  3  bit2 = sign, bits1:0 = size.
REQ-011 in_ready  output  1  store accepted this cycle.
REQ-012 MEM_ADDR2, MEM_WRITE_DATA  output  XLEN each  head-entry address and data.
REQ-013 MEM_WRITE  output  1  write request for head entry.
REQ-014 MEM_SIGN  output  1; MEM_SIZE  output  2  head-entry type fields.
REQ-015 mem_resp_valid  input  1  memory responds this cycle.
REQ-016 mem_resp  input  1  1 = write committed, 0 = retry.
REQ-017 done  output  1; done_tag  output  TAG_W  one-cycle completion pulse and its tag.
REQ-018 count  output  clog2(DEPTH)+1  occupied entries; full, empty  output  1 each.
REQ-019 ld_addr  input  XLEN; fwd_hit  output  1; fwd_data  output  XLEN  load forwarding port.

Function
REQ-020 Enqueue SHALL occur when in_valid, V1_valid, V2_valid, V3_valid are high and full is low; in_ready SHALL equal that condition.
REQ-021 On enqueue, entry SHALL store addr = V1+V2 (modulo 2^XLEN), V3, mem_type, in_tag at tail; tail SHALL advance and wrap from DEPTH-1 to 0.
REQ-022 Entries SHALL issue strictly in FIFO order; only the head is presented to memory.
REQ-023 Head FSM SHALL have states IDLE (empty) and REQ (head valid, MEM_WRITE=1); IDLE->REQ the cycle after first enqueue; REQ->IDLE when head pops and queue becomes empty.
REQ-024 In REQ, MEM_ADDR2, MEM_WRITE_DATA, MEM_SIGN, MEM_SIZE SHALL remain stable until mem_resp_valid&&mem_resp.
REQ-025 On mem_resp_valid&&mem_resp, head SHALL pop and done=1, done_tag=head tag in the next cycle, for exactly one cycle.
REQ-026 On mem_resp_valid&&!mem_resp, head SHALL remain, MEM_WRITE stays 1; no done pulse.
REQ-027 mem_resp_valid in IDLE SHALL be ignored.
REQ-028 Simultaneous enqueue and pop SHALL keep count unchanged; enqueue is refused when full even if a pop occurs the same cycle.
REQ-029 Enqueue into empty queue SHALL NOT present the entry to memory in the same cycle (one-cycle enqueue-to-request latency).
REQ-030 full = (count==DEPTH); empty = (count==0).
REQ-031 Pop-to-next-request latency SHALL be zero: the following entry is presented in the cycle after the pop.

Reset
REQ-032 RST SHALL, at the next edge, clear all entries, pointers and count, force IDLE; outputs: MEM_WRITE=0, done=0, done_tag=0, count=0, empty=1, full=0, fwd_hit=0, MEM_ADDR2/MEM_WRITE_DATA/MEM_SIZE/MEM_SIGN=0.
REQ-033 RST asserted mid-request SHALL discard pending stores without done pulses; in_ready SHALL be 0 while RST is high.

Configuration
REQ-034 With STORE_QUEUE_FWD_EN defined, fwd_hit SHALL be combinationally 1 when any valid entry with size 2'b10 has addr==ld_addr, and fwd_data SHALL be the youngest such entry's data.
REQ-035 Without STORE_QUEUE_FWD_EN, ports SHALL exist with fwd_hit=0, fwd_data=0 and no comparator logic.

Verification
REQ-036 Reset, enqueue V1=0x100,V2=0x4,V3=0xDEADBEEF,tag=3 -> next cycle MEM_WRITE=1, MEM_ADDR2=0x104; resp ok -> done=1, done_tag=3 one cycle, empty=1.
REQ-037 Enqueue 4 stores with DEPTH=4 -> full=1, in_ready=0 on fifth; issue order matches tags 0,1,2,3.
REQ-038 Head presented, mem_resp_valid=1, mem_resp=0 twice then 1 -> outputs stable across retries, single done pulse.
REQ-039 Full queue, pop plus in_valid same cycle -> enqueue refused, count=3; next cycle enqueue accepted, count=4; pointers wrap correctly over 10 stores.
REQ-040 RST asserted with 3 pending -> next cycle MEM_WRITE=0, count=0, no done pulses.
REQ-041 FWD_EN: two word stores to 0x200 data 0x11 then 0x22, ld_addr=0x200 -> fwd_hit=1, fwd_data=0x22; without macro fwd_hit=0.
